// File: rtl/head_launch_pkg.sv
// Shared types, cfg select codes and default widths for the head array launcher.
package head_launch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_STATE,
    ST_START,
    ST_WAIT,
    ST_DONE
  } launch_state_t;

  localparam logic [2:0] CFG_SEL_OP    = 3'd0;
  localparam logic [2:0] CFG_SEL_USR   = 3'd1;
  localparam logic [2:0] CFG_SEL_MODEL = 3'd2;
  localparam logic [2:0] CFG_SEL_PMU   = 3'd3;
  localparam logic [2:0] CFG_SEL_RC    = 3'd4;

  localparam int NUM_HEAD_DEF    = 16;
  localparam int STATE_W_DEF     = 32;
  localparam int OP_CFG_W_DEF    = 41;
  localparam int USR_CFG_W_DEF   = 12;
  localparam int MODEL_CFG_W_DEF = 30;
  localparam int PMU_CFG_W_DEF   = 4;
  localparam int RC_CFG_W_DEF    = 84;
  localparam int CFG_WD_W_DEF    = 84;
  localparam int TIMEOUT_CYC_DEF = 65535;

endpackage

// File: rtl/head_array_launcher_if.sv
// Host-side config write and launch command interface of the head array launcher.
interface head_array_launcher_if
  import head_launch_pkg::*;
#(
  parameter int NUM_HEAD = NUM_HEAD_DEF,
  parameter int STATE_W  = STATE_W_DEF,
  parameter int CFG_WD_W = CFG_WD_W_DEF
);
  logic                cfg_wen;
  logic [2:0]          cfg_sel;
  logic [CFG_WD_W-1:0] cfg_wdata;
  logic                cmd_vld;
  logic                cmd_rdy;
  logic [STATE_W-1:0]  cmd_state;
  logic [NUM_HEAD-1:0] cmd_head_mask;
  logic                abort;
  logic                busy;
  logic                done;
  logic                done_timeout;
  logic [NUM_HEAD-1:0] finish_map;

  modport master (
    output cfg_wen, cfg_sel, cfg_wdata, cmd_vld, cmd_state, cmd_head_mask, abort,
    input  cmd_rdy, busy, done, done_timeout, finish_map
  );

  modport slave (
    input  cfg_wen, cfg_sel, cfg_wdata, cmd_vld, cmd_state, cmd_head_mask, abort,
    output cmd_rdy, busy, done, done_timeout, finish_map
  );
endinterface

// File: rtl/head_cfg_shadow.sv
// Five shadow config registers with dirty tracking; a broadcast pulse copies dirty shadows
// to the output buses and strobes their valids for one cycle.
module head_cfg_shadow
  import head_launch_pkg::*;
#(
  parameter int CFG_WD_W    = CFG_WD_W_DEF,
  parameter int OP_CFG_W    = OP_CFG_W_DEF,
  parameter int USR_CFG_W   = USR_CFG_W_DEF,
  parameter int MODEL_CFG_W = MODEL_CFG_W_DEF,
  parameter int PMU_CFG_W   = PMU_CFG_W_DEF,
  parameter int RC_CFG_W    = RC_CFG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wen,
  input  logic [2:0]             sel,
  input  logic [CFG_WD_W-1:0]    wdata,
  input  logic                   bcast,
  output logic [OP_CFG_W-1:0]    op_cfg,
  output logic [USR_CFG_W-1:0]   usr_cfg,
  output logic [MODEL_CFG_W-1:0] model_cfg,
  output logic [PMU_CFG_W-1:0]   pmu_cfg,
  output logic [RC_CFG_W-1:0]    rc_cfg,
  output logic [4:0]             vld
);

  for (genvar g = 0; g < 5; g++) begin : g_ch
    localparam int W = (g == 0) ? OP_CFG_W  :
                       (g == 1) ? USR_CFG_W :
                       (g == 2) ? MODEL_CFG_W :
                       (g == 3) ? PMU_CFG_W : RC_CFG_W;

    logic [W-1:0] shadow_q;
    logic [W-1:0] out_q;
    logic         dirty_q;
    logic         vld_q;
    logic         wr;
    logic         send;

    assign wr   = wen && (sel == 3'(g));
    // A write landing in the broadcast cycle is sent straight through.
    assign send = bcast && (dirty_q || wr);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        out_q    <= '0;
        dirty_q  <= 1'b0;
        vld_q    <= 1'b0;
      end else begin
        vld_q <= send;
        if (wr) shadow_q <= wdata[W-1:0];
        if (send) out_q <= wr ? wdata[W-1:0] : shadow_q;
        if (wr) dirty_q <= 1'b1;
        else if (bcast) dirty_q <= 1'b0;
      end
    end

    assign vld[g] = vld_q;
  end

  assign op_cfg    = g_ch[0].out_q;
  assign usr_cfg   = g_ch[1].out_q;
  assign model_cfg = g_ch[2].out_q;
  assign pmu_cfg   = g_ch[3].out_q;
  assign rc_cfg    = g_ch[4].out_q;

endmodule

// File: rtl/head_array_launcher.sv
// Launch sequencer for an array of heads: cfg broadcast, state update, start, finish collection.
// Optional WAIT timeout enabled by defining HEAD_LAUNCH_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | ready for a launch command
//   CFG      | dirty config strobes on the buses
//   STATE    | control_state updated and strobed
//   START    | head_start pulse to the selected heads
//   WAIT     | collecting finishes (optionally bounded)
//   DONE     | one-cycle completion pulse
module head_array_launcher
  import head_launch_pkg::*;
#(
  parameter int NUM_HEAD    = NUM_HEAD_DEF,
  parameter int STATE_W     = STATE_W_DEF,
  parameter int OP_CFG_W    = OP_CFG_W_DEF,
  parameter int USR_CFG_W   = USR_CFG_W_DEF,
  parameter int MODEL_CFG_W = MODEL_CFG_W_DEF,
  parameter int PMU_CFG_W   = PMU_CFG_W_DEF,
  parameter int RC_CFG_W    = RC_CFG_W_DEF,
  parameter int CFG_WD_W    = CFG_WD_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  head_array_launcher_if.slave   host,
  output logic [OP_CFG_W-1:0]    op_cfg,
  output logic [USR_CFG_W-1:0]   usr_cfg,
  output logic [MODEL_CFG_W-1:0] model_cfg,
  output logic [PMU_CFG_W-1:0]   pmu_cfg,
  output logic [RC_CFG_W-1:0]    rc_cfg,
  output logic                   op_cfg_vld,
  output logic                   usr_cfg_vld,
  output logic                   model_cfg_vld,
  output logic                   pmu_cfg_vld,
  output logic                   rc_cfg_vld,
  output logic [STATE_W-1:0]     control_state,
  output logic                   control_state_update,
  output logic [NUM_HEAD-1:0]    head_start,
  input  logic [NUM_HEAD-1:0]    head_finish
);

  launch_state_t       state_q, state_nxt;
  logic                rdy_q;
  logic                accept;
  logic [NUM_HEAD-1:0] mask_q, fmap_q, fmap_nxt;
  logic [STATE_W-1:0]  st_lat_q, ctrl_q;
  logic                update_q;
  logic                timed_out;
  logic [4:0]          vld;

  assign host.cmd_rdy = rdy_q && (state_q == ST_IDLE);
  assign accept       = host.cmd_vld && host.cmd_rdy;
  assign fmap_nxt     = fmap_q | (head_finish & mask_q);

`ifdef HEAD_LAUNCH_TIMEOUT_EN
  logic [31:0] wait_cnt_q;
  logic        timeout_q;
  assign timed_out = (state_q == ST_WAIT) && (wait_cnt_q == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + 32'd1 : '0;
      timeout_q  <= (state_q == ST_WAIT) && (state_nxt == ST_DONE) && (fmap_nxt != mask_q);
    end
  end
  assign host.done_timeout = (state_q == ST_DONE) && timeout_q;
`else
  assign timed_out         = 1'b0;
  assign host.done_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_nxt = ST_CFG;
      ST_CFG:   state_nxt = ST_STATE;
      ST_STATE: state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (fmap_nxt == mask_q || timed_out) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (host.abort && state_q != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b0;
      mask_q   <= '0;
      st_lat_q <= '0;
      fmap_q   <= '0;
      ctrl_q   <= '0;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      rdy_q    <= 1'b1;
      update_q <= (state_q == ST_CFG) && (state_nxt == ST_STATE);
      if ((state_q == ST_CFG) && (state_nxt == ST_STATE)) ctrl_q <= st_lat_q;
      if (accept) begin
        mask_q   <= host.cmd_head_mask;
        st_lat_q <= host.cmd_state;
        fmap_q   <= '0;
      end else if (state_q == ST_WAIT) begin
        fmap_q <= fmap_nxt;
      end
    end
  end

  head_cfg_shadow #(
    .CFG_WD_W   (CFG_WD_W),
    .OP_CFG_W   (OP_CFG_W),
    .USR_CFG_W  (USR_CFG_W),
    .MODEL_CFG_W(MODEL_CFG_W),
    .PMU_CFG_W  (PMU_CFG_W),
    .RC_CFG_W   (RC_CFG_W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (host.cfg_wen),
    .sel      (host.cfg_sel),
    .wdata    (host.cfg_wdata),
    .bcast    (accept),
    .op_cfg   (op_cfg),
    .usr_cfg  (usr_cfg),
    .model_cfg(model_cfg),
    .pmu_cfg  (pmu_cfg),
    .rc_cfg   (rc_cfg),
    .vld      (vld)
  );

  assign op_cfg_vld           = vld[0];
  assign usr_cfg_vld          = vld[1];
  assign model_cfg_vld        = vld[2];
  assign pmu_cfg_vld          = vld[3];
  assign rc_cfg_vld           = vld[4];
  assign control_state        = ctrl_q;
  assign control_state_update = update_q;
  assign head_start           = (state_q == ST_START) ? mask_q : '0;
  assign host.busy            = (state_q != ST_IDLE);
  assign host.done            = (state_q == ST_DONE);
  assign host.finish_map      = fmap_q;

endmodule

// File: tb/tb_head_array_launcher.sv
// Scoreboard bench for head_array_launcher; timeout scenario runs when HEAD_LAUNCH_TIMEOUT_EN is defined.
module tb_head_array_launcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [40:0] op_cfg;
  logic [11:0] usr_cfg;
  logic [29:0] model_cfg;
  logic [3:0]  pmu_cfg;
  logic [83:0] rc_cfg;
  logic        op_cfg_vld, usr_cfg_vld, model_cfg_vld, pmu_cfg_vld, rc_cfg_vld;
  logic [31:0] control_state;
  logic        control_state_update;
  logic [15:0] head_start;
  logic [15:0] head_finish = '0;

  head_array_launcher_if #(.NUM_HEAD(16), .STATE_W(32), .CFG_WD_W(84)) hif ();

  head_array_launcher #(.TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst_n(rst_n), .host(hif.slave),
    .op_cfg(op_cfg), .usr_cfg(usr_cfg), .model_cfg(model_cfg), .pmu_cfg(pmu_cfg), .rc_cfg(rc_cfg),
    .op_cfg_vld(op_cfg_vld), .usr_cfg_vld(usr_cfg_vld), .model_cfg_vld(model_cfg_vld),
    .pmu_cfg_vld(pmu_cfg_vld), .rc_cfg_vld(rc_cfg_vld),
    .control_state(control_state), .control_state_update(control_state_update),
    .head_start(head_start), .head_finish(head_finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [83:0] val;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int tc;

  logic [83:0] m_shadow [5];
  logic        m_dirty  [5];

  // kinds 0..4 cfg strobes, 5 update, 6 head_start, 7 done
  logic [7:0]  obs_stb;
  logic [83:0] obs_val [8];
  always_comb begin
    obs_stb    = {hif.done, head_start != 16'h0, control_state_update,
                  rc_cfg_vld, pmu_cfg_vld, model_cfg_vld, usr_cfg_vld, op_cfg_vld};
    obs_val[0] = 84'(op_cfg);
    obs_val[1] = 84'(usr_cfg);
    obs_val[2] = 84'(model_cfg);
    obs_val[3] = 84'(pmu_cfg);
    obs_val[4] = rc_cfg;
    obs_val[5] = 84'(control_state);
    obs_val[6] = 84'(head_start);
    obs_val[7] = 84'({hif.done_timeout, hif.finish_map});
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (obs_stb[k]) begin
          exp_t e;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d val=%h, required none", k, cyc, obs_val[k]);
          end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.cyc !== cyc || e.val !== obs_val[k]) begin
              n_err++;
              $display("FAIL event got kind=%0d cyc=%0d val=%h, required kind=%0d cyc=%0d val=%h",
                       k, cyc, obs_val[k], e.kind, e.cyc, e.val);
            end
          end
        end
      end
    end
  end

  function automatic logic [83:0] trunc(input int s, input logic [83:0] d);
    int w;
    w = (s == 0) ? 41 : (s == 1) ? 12 : (s == 2) ? 30 : (s == 3) ? 4 : 84;
    return d & ((84'd1 << w) - 84'd1);
  endfunction

  task automatic push(input int c, input int k, input logic [83:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_shadow[i] = '0;
      m_dirty[i]  = 1'b0;
    end
  endtask

  task automatic model_write(input int s, input logic [83:0] d);
    if (s < 5) begin
      m_shadow[s] = trunc(s, d);
      m_dirty[s]  = 1'b1;
    end
  endtask

  task automatic cfg_write(input int s, input logic [83:0] d);
    hif.cfg_wen = 1'b1; hif.cfg_sel = 3'(s); hif.cfg_wdata = d;
    model_write(s, d);
    @(posedge clk); #1;
    hif.cfg_wen = 1'b0;
  endtask

  task automatic launch(input logic [31:0] st, input logic [15:0] m,
                        input bit wr, input int ws, input logic [83:0] wd, output int t);
    hif.cmd_vld = 1'b1; hif.cmd_state = st; hif.cmd_head_mask = m;
    if (wr) begin
      hif.cfg_wen = 1'b1; hif.cfg_sel = 3'(ws); hif.cfg_wdata = wd;
      model_write(ws, wd);
    end
    n_cmp++;
    if (hif.cmd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL launch_rdy got %b, required 1", hif.cmd_rdy);
    end
    t = cyc;
    for (int i = 0; i < 5; i++)
      if (m_dirty[i]) begin
        push(t + 1, i, m_shadow[i]);
        m_dirty[i] = 1'b0;
      end
    push(t + 2, 5, 84'(st));
    if (m != 16'h0) push(t + 3, 6, 84'(m));
    @(posedge clk); #1;
    hif.cmd_vld = 1'b0; hif.cfg_wen = 1'b0;
  endtask

  task automatic test_reset();
    hif.cfg_wen = 0; hif.cfg_sel = 0; hif.cfg_wdata = 0; hif.cmd_vld = 0;
    hif.cmd_state = 0; hif.cmd_head_mask = 0; hif.abort = 0;
    model_reset();
    #3;
    n_cmp++;
    if ({hif.cmd_rdy, hif.busy, hif.done, hif.done_timeout, hif.finish_map, head_start,
         control_state_update, control_state, op_cfg_vld, rc_cfg_vld, op_cfg, rc_cfg} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got rdy=%b busy=%b done=%b cs=%h op=%h, required all 0",
               hif.cmd_rdy, hif.busy, hif.done, control_state, op_cfg);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (hif.cmd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rdy_after_reset got %b, required 1", hif.cmd_rdy);
    end
  endtask

  task automatic test_cfg_launch();
    cfg_write(0, 84'h1);
    cfg_write(4, 84'hABC_DEF_123_456_789);
    launch(32'd4, 16'h0003, 0, 0, '0, tc);
  endtask

  task automatic test_finish_collect();
    goto(tc + 4); head_finish = 16'h0001;
    goto(tc + 5); head_finish = 16'h0000;
    goto(tc + 8); head_finish = 16'h0002;
    push(tc + 9, 7, 84'({1'b0, 16'h0003}));
    goto(tc + 9); head_finish = 16'h0000;
    goto(tc + 10);
    n_cmp++;
    if (hif.busy !== 1'b0 || hif.finish_map !== 16'h0003) begin
      n_err++;
      $display("FAIL after_done got busy=%b map=%h, required 0/0003", hif.busy, hif.finish_map);
    end
  endtask

  task automatic test_no_cfg_relaunch();
    launch(32'd7, 16'h0001, 0, 0, '0, tc);
    goto(tc + 4);
    n_cmp++;
    if (hif.busy !== 1'b1 || op_cfg !== 41'h1) begin
      n_err++;
      $display("FAIL hold_cfg got busy=%b op=%h, required 1/1", hif.busy, op_cfg);
    end
    head_finish = 16'h0001;
    push(tc + 5, 7, 84'({1'b0, 16'h0001}));
    goto(tc + 5); head_finish = 16'h0000;
    goto(tc + 7);
  endtask

  task automatic test_cfg_during_launch();
    launch(32'd9, 16'h0000, 1, 1, 84'hA5A, tc);
    cfg_write(1, 84'h3C3);
    push(tc + 5, 7, 84'h0);
    goto(tc + 7);
    launch(32'd10, 16'h0000, 0, 0, '0, tc);
    push(tc + 5, 7, 84'h0);
    goto(tc + 7);
    n_cmp++;
    if (usr_cfg !== 12'h3C3 || rc_cfg !== 84'hABC_DEF_123_456_789) begin
      n_err++;
      $display("FAIL usr_resent got usr=%h rc=%h, required 3C3/ABCDEF123456789", usr_cfg, rc_cfg);
    end
  endtask

  task automatic test_abort_reset();
    launch(32'd5, 16'hFFFF, 0, 0, '0, tc);
    goto(tc + 4); head_finish = 16'h0004;
    goto(tc + 5); head_finish = 16'h0000;
    goto(tc + 6); hif.abort = 1'b1;
    goto(tc + 7); hif.abort = 1'b0;
    n_cmp++;
    if (hif.busy !== 1'b0 || hif.cmd_rdy !== 1'b1 || hif.finish_map !== 16'h0004) begin
      n_err++;
      $display("FAIL abort got busy=%b rdy=%b map=%h, required 0/1/0004",
               hif.busy, hif.cmd_rdy, hif.finish_map);
    end
    goto(tc + 10);
    launch(32'd6, 16'hFFFF, 0, 0, '0, tc);
    goto(tc + 5);
    n_cmp++;
    if (hif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_wait got %b, required 1", hif.busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hif.busy, hif.cmd_rdy, hif.done, control_state, op_cfg, usr_cfg, rc_cfg, hif.finish_map} !== '0) begin
      n_err++;
      $display("FAIL mid_wait_reset got busy=%b rdy=%b cs=%h op=%h map=%h, required all 0",
               hif.busy, hif.cmd_rdy, control_state, op_cfg, hif.finish_map);
    end
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (hif.cmd_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rdy_after_mid_reset got %b, required 1", hif.cmd_rdy);
    end
  endtask

  task automatic test_zero_mask();
    launch(32'hDEAD_BEEF, 16'h0000, 0, 0, '0, tc);
    push(tc + 5, 7, 84'h0);
    goto(tc + 7);
  endtask

`ifdef HEAD_LAUNCH_TIMEOUT_EN
  task automatic test_timeout();
    launch(32'd3, 16'h0005, 0, 0, '0, tc);
    goto(tc + 4); head_finish = 16'h0001;
    goto(tc + 5); head_finish = 16'h0000;
    push(tc + 54, 7, 84'({1'b1, 16'h0001}));
    goto(tc + 56);
    n_cmp++;
    if (hif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_idle got busy=%b, required 0", hif.busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cfg_launch();
    test_finish_collect();
    test_no_cfg_relaunch();
    test_cfg_during_launch();
    test_abort_reset();
    test_zero_mask();
`ifdef HEAD_LAUNCH_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending, required 0 (first kind=%0d cyc=%0d)",
               exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
